// File: rtl/ex_co_arbiter.sv
`default_nettype none
// ============================================================================
// Module : ex_co_arbiter
// Brief  : One holding register per FU, round-robin drained onto one CDB slot.
// Rev    : 1.0  initial release
// ============================================================================
module ex_co_arbiter #(
    parameter int NUM_SRC  = 4,
    parameter int XLEN     = 32,
    parameter int PREG_W   = 6,
    parameter int ROB_W    = 5,
    parameter int FU_IDX_W = 2,
    parameter int FTYPE_W  = 3
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          squash,
    input  logic                          cdb_stall,
    input  logic [NUM_SRC-1:0]            src_valid,
    output logic [NUM_SRC-1:0]            src_ready,
    input  logic [NUM_SRC*PREG_W-1:0]     src_dest_idx,
    input  logic [NUM_SRC*XLEN-1:0]       src_result,
    input  logic [NUM_SRC*XLEN-1:0]       src_npc,
    input  logic [NUM_SRC-1:0]            src_take_branch,
    input  logic [NUM_SRC*ROB_W-1:0]      src_rob_index,
    input  logic [NUM_SRC*FTYPE_W-1:0]    src_ftype,
    input  logic [NUM_SRC*FU_IDX_W-1:0]   src_fu_index,
    output logic                          out_valid,
    output logic [PREG_W-1:0]             out_dest_idx,
    output logic [XLEN-1:0]               out_result,
    output logic [XLEN-1:0]               out_npc,
    output logic                          out_take_branch,
    output logic [ROB_W-1:0]              out_rob_index,
    output logic [FTYPE_W-1:0]            out_ftype,
    output logic [FU_IDX_W-1:0]           out_fu_index,
    output logic [$clog2(NUM_SRC)-1:0]    out_src,
    output logic [$clog2(NUM_SRC):0]      pending_cnt
);

    localparam int c_src_w = $clog2(NUM_SRC);
    localparam int c_cnt_w = c_src_w + 1;
    localparam logic [c_src_w-1:0] c_one = 1;

    // Per-source views of the flattened input buses
    logic [PREG_W-1:0]   w_src_dest   [NUM_SRC];
    logic [XLEN-1:0]     w_src_result [NUM_SRC];
    logic [XLEN-1:0]     w_src_npc    [NUM_SRC];
    logic [ROB_W-1:0]    w_src_rob    [NUM_SRC];
    logic [FTYPE_W-1:0]  w_src_ftype  [NUM_SRC];
    logic [FU_IDX_W-1:0] w_src_fu     [NUM_SRC];

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_unpack
            assign w_src_dest[gi]   = src_dest_idx[gi*PREG_W +: PREG_W];
            assign w_src_result[gi] = src_result[gi*XLEN +: XLEN];
            assign w_src_npc[gi]    = src_npc[gi*XLEN +: XLEN];
            assign w_src_rob[gi]    = src_rob_index[gi*ROB_W +: ROB_W];
            assign w_src_ftype[gi]  = src_ftype[gi*FTYPE_W +: FTYPE_W];
            assign w_src_fu[gi]     = src_fu_index[gi*FU_IDX_W +: FU_IDX_W];
        end
    endgenerate

    logic [NUM_SRC-1:0]  r_hold_valid;
    logic [PREG_W-1:0]   r_hold_dest   [NUM_SRC];
    logic [XLEN-1:0]     r_hold_result [NUM_SRC];
    logic [XLEN-1:0]     r_hold_npc    [NUM_SRC];
    logic [NUM_SRC-1:0]  r_hold_tb;
    logic [ROB_W-1:0]    r_hold_rob    [NUM_SRC];
    logic [FTYPE_W-1:0]  r_hold_ftype  [NUM_SRC];
    logic [FU_IDX_W-1:0] r_hold_fu     [NUM_SRC];

    logic [c_src_w-1:0]  r_rr_ptr;
    logic                r_out_valid;
    logic [PREG_W-1:0]   r_out_dest;
    logic [XLEN-1:0]     r_out_result;
    logic [XLEN-1:0]     r_out_npc;
    logic                r_out_tb;
    logic [ROB_W-1:0]    r_out_rob;
    logic [FTYPE_W-1:0]  r_out_ftype;
    logic [FU_IDX_W-1:0] r_out_fu;
    logic [c_src_w-1:0]  r_out_src;

    logic [NUM_SRC-1:0]  w_grant;
    logic                w_grant_any;
    logic [c_src_w-1:0]  w_grant_idx;
    logic [NUM_SRC-1:0]  w_accept;
    logic [c_cnt_w-1:0]  w_pending;

    // Round-robin search starting at r_rr_ptr; squash and stall suppress it
    always_comb begin
        logic [c_src_w-1:0] v_idx;
        v_idx       = '0;
        w_grant_any = 1'b0;
        w_grant_idx = '0;
        w_grant     = '0;
        if (!cdb_stall && !squash) begin
            for (int k = 0; k < NUM_SRC; k++) begin
                v_idx = r_rr_ptr + k[c_src_w-1:0];
                if (!w_grant_any && r_hold_valid[v_idx]) begin
                    w_grant_any = 1'b1;
                    w_grant_idx = v_idx;
                end
            end
        end
        if (w_grant_any) begin
            w_grant[w_grant_idx] = 1'b1;
        end
    end

    // An entry draining this cycle may be refilled on the same edge
    assign src_ready = {NUM_SRC{~squash & ~reset}} & (~r_hold_valid | w_grant);
    assign w_accept  = src_valid & src_ready;

    always_comb begin
        w_pending = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_pending = w_pending + {{c_src_w{1'b0}}, r_hold_valid[i]};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_hold_valid <= '0;
            r_hold_tb    <= '0;
            for (int i = 0; i < NUM_SRC; i++) begin
                r_hold_dest[i]   <= '0;
                r_hold_result[i] <= '0;
                r_hold_npc[i]    <= '0;
                r_hold_rob[i]    <= '0;
                r_hold_ftype[i]  <= '0;
                r_hold_fu[i]     <= '0;
            end
        end else if (squash) begin
            r_hold_valid <= '0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (w_accept[i]) begin
                    r_hold_valid[i]  <= 1'b1;
                    r_hold_dest[i]   <= w_src_dest[i];
                    r_hold_result[i] <= w_src_result[i];
                    r_hold_npc[i]    <= w_src_npc[i];
                    r_hold_tb[i]     <= src_take_branch[i];
                    r_hold_rob[i]    <= w_src_rob[i];
                    r_hold_ftype[i]  <= w_src_ftype[i];
                    r_hold_fu[i]     <= w_src_fu[i];
                end else if (w_grant[i]) begin
                    r_hold_valid[i]  <= 1'b0;
                end
            end
        end
    end

    // Payload holds across idle cycles; only out_valid drops
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rr_ptr     <= '0;
            r_out_valid  <= 1'b0;
            r_out_dest   <= '0;
            r_out_result <= '0;
            r_out_npc    <= '0;
            r_out_tb     <= 1'b0;
            r_out_rob    <= '0;
            r_out_ftype  <= '0;
            r_out_fu     <= '0;
            r_out_src    <= '0;
        end else begin
            r_out_valid <= w_grant_any;
            if (w_grant_any) begin
                r_out_dest   <= r_hold_dest[w_grant_idx];
                r_out_result <= r_hold_result[w_grant_idx];
                r_out_npc    <= r_hold_npc[w_grant_idx];
                r_out_tb     <= r_hold_tb[w_grant_idx];
                r_out_rob    <= r_hold_rob[w_grant_idx];
                r_out_ftype  <= r_hold_ftype[w_grant_idx];
                r_out_fu     <= r_hold_fu[w_grant_idx];
                r_out_src    <= w_grant_idx;
                r_rr_ptr     <= w_grant_idx + c_one;
            end
        end
    end

    assign out_valid       = r_out_valid;
    assign out_dest_idx    = r_out_dest;
    assign out_result      = r_out_result;
    assign out_npc         = r_out_npc;
    assign out_take_branch = r_out_tb;
    assign out_rob_index   = r_out_rob;
    assign out_ftype       = r_out_ftype;
    assign out_fu_index    = r_out_fu;
    assign out_src         = r_out_src;
    assign pending_cnt     = w_pending;

endmodule
`default_nettype wire

// File: doc/ex_co_arbiter.md
Name: ex_co_arbiter

Overview:
- Sits between the functional units and the complete stage.
- Each FU hands its result to a private one-entry holding register.
- A round-robin arbiter drains one held result per cycle into a registered output that drives the complete stage's execute-to-complete input (single CDB).
- Supports CDB stall and mispredict squash.

Parameters:
- NUM_SRC, 4, number of FU result sources (power of two, >=2)
- XLEN, 32, result/NPC width
- PREG_W, 6, physical destination register index width
- ROB_W, 5, ROB index width
- FU_IDX_W, 2, issued FU index width
- FTYPE_W, 3, function type code width

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- squash  in  1  mispredict flush: drop all held and outgoing results
- cdb_stall  in  1  CDB unavailable this cycle; no grant
- src_valid  in  NUM_SRC  per-FU result valid
- src_ready  out  NUM_SRC  per-FU holding register can accept
- src_dest_idx  in  NUM_SRC*PREG_W  physical dest (0 = no writeback)
- src_result  in  NUM_SRC*XLEN  FU result
- src_npc  in  NUM_SRC*XLEN  PC+4 of instruction
- src_take_branch  in  NUM_SRC  branch taken
- src_rob_index  in  NUM_SRC*ROB_W  ROB entry
- src_ftype  in  NUM_SRC*FTYPE_W  function type
- src_fu_index  in  NUM_SRC*FU_IDX_W  issued FU index
- out_valid  out  1  registered result valid to complete stage
- out_dest_idx, out_result, out_npc, out_take_branch, out_rob_index, out_ftype, out_fu_index  out  widths as above  registered payload of granted source
- out_src  out  log2(NUM_SRC)  source that produced the current output
- pending_cnt  out  log2(NUM_SRC)+1  number of occupied holding registers

Behaviour:
- Reset (synchronous):
  - hold_valid all 0, out_valid 0, all out_* payload 0, rr_ptr 0, pending_cnt 0.
  - src_ready during a reset cycle is 0.
- Accept:
  - src_ready[i] = ~squash & ~reset & (~hold_valid[i] | grant[i]). This is combinational; a source may refill in the same cycle its entry drains.
  - On src_valid[i] & src_ready[i], capture the payload into hold[i] and set hold_valid[i] on the next edge.
  - src_valid while not ready is ignored. The source must hold its result.
- Arbitrate (combinational):
  - If ~cdb_stall & ~squash, grant the first i with hold_valid[i], searching rr_ptr, rr_ptr+1, ... mod NUM_SRC.
  - At most one grant per cycle.
- Output register, at the clock edge:
  - out_valid <= |grant.
  - The payload and out_src load from the granted entry when granted. Otherwise the payload holds its value and out_valid is 0.
  - hold_valid[grant] is cleared unless the same cycle refills it.
  - rr_ptr <= granted index + 1 mod NUM_SRC. It is unchanged when there is no grant.
- Latency:
  - 2 cycles minimum: accepted at edge t, granted during cycle t, out_valid visible after edge t+1.
  - Peak throughput is 1 result/cycle in aggregate and 1 result/cycle per source.
- Stall:
  - No grant, out_valid 0 next cycle, holding registers keep contents.
  - Sources whose entries are full see src_ready 0.
- Squash:
  - Next edge: hold_valid all 0, out_valid 0. rr_ptr is unchanged.
  - Inputs presented in the squash cycle are dropped (src_ready 0).
  - Squash overrides cdb_stall and any grant.
- pending_cnt: popcount of registered hold_valid.
- Fairness: a held entry is granted within NUM_SRC non-stalled cycles.
- dest_idx 0 results still flow; the complete stage gates the write.

Test Plan:
- Single source: reset, then src_valid[2]=1 for one cycle with result=0xDEAD_BEEF, dest=5, rob=3 -> out_valid=1 exactly 2 cycles later with those values, out_src=2, then out_valid=0.
- All four sources valid in the same cycle from rr_ptr=0 -> out_src sequence 0,1,2,3 on consecutive cycles; pending_cnt 4,3,2,1,0.
- Continuous valid on source 1 alone -> src_ready[1] stays 1, out_valid=1 every cycle after the first 2, and results arrive in order.
- cdb_stall held 3 cycles with 2 entries held -> out_valid=0 and pending_cnt=2 throughout; after release, both drain on 2 consecutive cycles.
- Squash with 3 entries held, an output pending, and src_valid[0]=1 -> next cycle out_valid=0, pending_cnt=0, source 0's input is not captured.
- Reset asserted mid-drain -> next cycle all outputs 0; a later single input to source 3 is granted first (rr_ptr=0 search).
